// File: rtl/genetico_eval_ctrl.sv
// Chromosome loader and exhaustive-evaluation sequencer for the genetico array.
// A serial chromosome is shifted into a flat config register that drives the
// array directly. On start, all 256 input vectors are swept and each array
// output is scored bitwise against a synchronous expected-output table.
module genetico_eval_ctrl #(
  parameter int unsigned N_LE      = 25,
  parameter int unsigned LE_CFG_W  = 15,
  parameter int unsigned N_OUT     = 8,
  parameter int unsigned OUT_SEL_W = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  input  logic                          cfg_bit,
  output logic                          cfg_ready,
  input  logic                          cfg_clear,
  input  logic                          start,
  output logic [N_LE*LE_CFG_W-1:0]      conf_les,
  output logic [N_OUT*OUT_SEL_W-1:0]    conf_outs,
  output logic [7:0]                    chrom_in,
  input  logic [7:0]                    chrom_out,
  output logic [7:0]                    exp_addr,
  input  logic [7:0]                    exp_data,
  output logic                          loaded,
  output logic                          busy,
  output logic                          done,
  output logic [11:0]                   fitness
);

  localparam int unsigned LES_BITS = N_LE * LE_CFG_W;
  localparam int unsigned CFG_BITS = LES_BITS + N_OUT * OUT_SEL_W;
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoaded,
    StEval,
    StDrain,
    StDone
  } state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] cfg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          vec_q;
  logic [7:0]          pipe_q;
  logic                cmp_valid_q;
  logic [11:0]         acc_q;
  logic [11:0]         fitness_q;
  logic                ready_q;
  logic                loaded_q;
  logic                busy_q;
  logic                done_q;

  logic                accept;
  logic [3:0]          match_cnt;
  logic [11:0]         acc_next;

  assign accept    = cfg_valid && ready_q;

  assign conf_les  = cfg_q[LES_BITS-1:0];
  assign conf_outs = cfg_q[CFG_BITS-1:LES_BITS];
  assign chrom_in  = vec_q;
  assign exp_addr  = vec_q;
  assign cfg_ready = ready_q;
  assign loaded    = loaded_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fitness   = fitness_q;

  // Count bits where the pipelined array output agrees with the table entry.
  always_comb begin
    logic [7:0] agree;
    agree     = ~(pipe_q ^ exp_data);
    match_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      match_cnt = match_cnt + {3'b0, agree[i]};
    end
    acc_next = acc_q + {8'b0, match_cnt};
  end

  // Config shift register: new bits enter at the top so the first bit ends at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (cfg_clear) begin
      cfg_q <= '0;
    end else if (accept) begin
      cfg_q <= {cfg_bit, cfg_q[CFG_BITS-1:1]};
    end
  end

  // Load/evaluate sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      vec_q       <= '0;
      pipe_q      <= '0;
      cmp_valid_q <= 1'b0;
      acc_q       <= '0;
      fitness_q   <= '0;
      ready_q     <= 1'b1;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (cfg_clear) begin
      // Abandon everything except the last reported fitness.
      state_q     <= StIdle;
      cnt_q       <= '0;
      vec_q       <= '0;
      pipe_q      <= '0;
      cmp_valid_q <= 1'b0;
      acc_q       <= '0;
      ready_q     <= 1'b1;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q  <= StLoaded;
              ready_q  <= 1'b0;
              loaded_q <= 1'b1;
            end
          end
        end
        StLoaded: begin
          if (start) begin
            state_q     <= StEval;
            vec_q       <= '0;
            acc_q       <= '0;
            cmp_valid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StEval: begin
          // exp_data lags its address by one cycle, so compare against the
          // array output captured one cycle earlier.
          pipe_q      <= chrom_out;
          cmp_valid_q <= 1'b1;
          if (cmp_valid_q) begin
            acc_q <= acc_next;
          end
          if (vec_q == 8'hff) begin
            state_q <= StDrain;
          end else begin
            vec_q <= vec_q + 8'd1;
          end
        end
        StDrain: begin
          acc_q       <= acc_next;
          fitness_q   <= acc_next;
          cmp_valid_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StLoaded;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_genetico_eval_ctrl.sv
// Bench for genetico_eval_ctrl. The array is stood in for by a pass-through
// (chrom_out = chrom_in) and the expected table by a registered lookup whose
// contents depend on tbl_mode. Expected fitness values are pushed on start and
// checked by a monitor whenever done pulses.
module tb_genetico_eval_ctrl;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic         cfg_clear;
  logic         start;
  logic [374:0] conf_les;
  logic [47:0]  conf_outs;
  logic [7:0]   chrom_in;
  logic [7:0]   chrom_out;
  logic [7:0]   exp_addr;
  logic [7:0]   exp_data;
  logic         loaded;
  logic         busy;
  logic         done;
  logic [11:0]  fitness;

  typedef struct {
    longint fit;
    longint t0;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           errors;
  int           checks;
  longint       cyc;
  int           tbl_mode;
  logic [422:0] pat;

  genetico_eval_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_clear (cfg_clear),
    .start     (start),
    .conf_les  (conf_les),
    .conf_outs (conf_outs),
    .chrom_in  (chrom_in),
    .chrom_out (chrom_out),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .loaded    (loaded),
    .busy      (busy),
    .done      (done),
    .fitness   (fitness)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Identity array stand-in.
  assign chrom_out = chrom_in;

  // Expected table with one-cycle read latency.
  always @(posedge clk) begin
    case (tbl_mode)
      0:       exp_data <= exp_addr;
      1:       exp_data <= exp_addr ^ 8'h01;
      default: exp_data <= ~exp_addr;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [422:0] act, input logic [422:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with fitness %0d expected no done", fitness);
      end else begin
        mon_e = sb.pop_front();
        chk("fitness", longint'(fitness), mon_e.fit);
        chk("done_latency", cyc - mon_e.t0, 258);
        chk("busy_at_done", longint'(busy), 1);
      end
    end
  end

  task automatic send_bits(input int from, input int upto, input bit gaps);
    int i;
    i = from;
    while (i < upto) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_bit   = pat[i];
        i++;
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input longint fit, input bit expect_run);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (expect_run) begin
      e.fit = fit;
      e.t0  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc       = 0;
    errors    = 0;
    checks    = 0;
    tbl_mode  = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    cfg_clear = 1'b0;
    start     = 1'b0;

    // Identity chromosome: LE configs zero, output j selects j.
    pat = '0;
    for (int j = 0; j < 8; j++) begin
      pat[375 + 6*j +: 6] = 6'(j);
    end

    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", longint'(cfg_ready), 1);
    chk("rst_loaded", longint'(loaded), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_fitness", longint'(fitness), 0);
    chk_wide("rst_conf", {conf_outs, conf_les}, '0);
    rst_n = 1'b1;

    // Partial load then start: must be ignored.
    send_bits(0, 100, 1'b0);
    pulse_start(0, 1'b0);
    @(negedge clk);
    chk("partial_start_busy", longint'(busy), 0);
    chk("partial_loaded", longint'(loaded), 0);
    send_bits(100, 422, 1'b1);
    chk("ready_before_last", longint'(cfg_ready), 1);
    send_bits(422, 423, 1'b0);
    chk("ready_after_last", longint'(cfg_ready), 0);
    chk("loaded_after_last", longint'(loaded), 1);
    chk_wide("conf_outs_pattern", {375'b0, conf_outs}, {375'b0, pat[422:375]});
    chk_wide("conf_les_pattern", {48'b0, conf_les}, {48'b0, pat[374:0]});

    // Identity table, with a stray start mid-evaluation.
    tbl_mode = 0;
    pulse_start(2048, 1'b1);
    repeat (50) @(negedge clk);
    chk("busy_mid_eval", longint'(busy), 1);
    pulse_start(0, 1'b0);
    wait_done();
    chk("busy_after_done", longint'(busy), 0);
    chk("chrom_in_hold", longint'(chrom_in), 255);

    tbl_mode = 1;
    pulse_start(1792, 1'b1);
    wait_done();
    tbl_mode = 2;
    pulse_start(0, 1'b1);
    wait_done();
    tbl_mode = 0;
    pulse_start(2048, 1'b1);
    wait_done();

    // Abort at vector 100.
    pulse_start(0, 1'b0);
    begin
      int n;
      n = 0;
      while (chrom_in != 8'd100 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reached_vec100", longint'(chrom_in), 100);
    end
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_cfg_ready", longint'(cfg_ready), 1);
    chk("abort_loaded", longint'(loaded), 0);
    chk("abort_fitness", longint'(fitness), 2048);
    chk_wide("abort_conf", {conf_outs, conf_les}, '0);
    repeat (300) @(negedge clk);

    // Async reset in the middle of an evaluation.
    send_bits(0, 423, 1'b0);
    pulse_start(2048, 1'b1);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_cfg_ready", longint'(cfg_ready), 1);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_done", longint'(done), 0);
    chk("arst_loaded", longint'(loaded), 0);
    chk("arst_fitness", longint'(fitness), 0);
    chk("arst_chrom_in", longint'(chrom_in), 0);
    chk_wide("arst_conf", {conf_outs, conf_les}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("scoreboard_empty", longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
